// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry prefetch buffer.
// Keeps up to DEPTH fetches in flight, buffers returned words with their PCs,
// and discards stale responses after an execute-stage redirect.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Valid never depends on the ready of the same channel. The memory
// response channel has no ready: the credit rule (outstanding + buffered never
// exceeds DEPTH) guarantees a free entry for every response that is kept.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_rsp_valid,
  input  logic [XLEN-1:0]            imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [XLEN-1:0]            instr_data,
  output logic [XLEN-1:0]            instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] respPc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   dropCnt;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rdPtr;
  logic [PW-1:0]   wrPtr;
  logic [XLEN-1:0] bufData [DEPTH];
  logic [XLEN-1:0] bufPc   [DEPTH];

  logic            issueFire;
  logic            rspWrite;
  logic            popFire;
  logic [CW:0]     creditUsed;
  logic [CW-1:0]   rspIn;
  logic [XLEN-1:0] redirectAligned;

  assign creditUsed      = {1'b0, outstanding} + {1'b0, count};
  assign rspIn           = CW'(imem_rsp_valid);
  assign redirectAligned = {redirect_pc[XLEN-1:2], 2'b00};

  // Requests are held off during reset, on redirect, while stale responses
  // are still being drained, and whenever every credit is in use.
  assign imem_req_valid = !reset && !redirect_valid && (creditUsed < DepthW) &&
                          (dropCnt == '0);
  assign imem_addr      = fetchPc;

  assign instr_valid = (count != '0) && !redirect_valid;
  assign instr_data  = bufData[rdPtr];
  assign instr_pc    = bufPc[rdPtr];
  assign fq_count    = count;

  assign issueFire = imem_req_valid && imem_req_ready;
  // A response is kept only when nothing stale is pending and no redirect is
  // flushing the buffer in the same cycle.
  assign rspWrite  = imem_rsp_valid && (dropCnt == '0) && !redirect_valid;
  assign popFire   = instr_valid && instr_ready;

  // Control state: PCs, credit/drop counters, occupancy and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
    end else if (redirect_valid) begin
      // Everything in flight becomes stale; the response arriving now is
      // discarded directly, so it is not counted in the new drop value.
      fetchPc     <= redirectAligned;
      respPc      <= redirectAligned;
      outstanding <= outstanding - rspIn;
      dropCnt     <= outstanding - rspIn;
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
    end else begin
      outstanding <= outstanding + CW'(issueFire) - rspIn;
      count       <= count + CW'(rspWrite) - CW'(popFire);
      if (issueFire) fetchPc <= fetchPc + XLEN'(4);
      if (imem_rsp_valid && (dropCnt != '0)) dropCnt <= dropCnt - CW'(1);
      if (rspWrite) begin
        wrPtr  <= wrPtr + PW'(1);
        respPc <= respPc + XLEN'(4);
      end
      if (popFire) rdPtr <= rdPtr + PW'(1);
    end
  end

  // Buffer storage: cleared on reset so the head outputs read as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bufData[i] <= '0;
        bufPc[i]   <= '0;
      end
    end else if (rspWrite) begin
      bufData[wrPtr] <= imem_rsp_data;
      bufPc[wrPtr]   <= respPc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomised checks of fetch_queue against a
// variable-latency memory model and an expected-instruction queue.
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [2:0]  fq_count;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .fq_count       (fq_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } pend_t;

  pend_t       pend[$];      // requests accepted by the memory model, in order
  logic [63:0] exp_q[$];     // expected {pc, data} for live requests
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          lastDue = -1;
  int          bufCount = 0;
  logic [31:0] expAddr = RESET_PC;
  bit          randReady = 0;
  bit          randLat = 0;
  int          firstPopCyc = -1;
  logic [31:0] firstPopPc = '0;
  bit          waitFirst = 0;
  logic [31:0] firstPcAfter = '0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_req_valid"}, 64'(imem_req_valid), 64'(0));
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'(RESET_PC));
    check({tag, "_instr_valid"}, 64'(instr_valid), 64'(0));
    check({tag, "_instr_data"}, 64'(instr_data), 64'(0));
    check({tag, "_instr_pc"}, 64'(instr_pc), 64'(0));
    check({tag, "_fq_count"}, 64'(fq_count), 64'(0));
  endtask

  // driver: one clock cycle; entered and left at the falling edge
  task automatic step();
    int          stale;
    logic        expReqValid;
    logic        reqFire;
    logic        rspFire;
    logic        rspLive;
    logic        popFire;
    logic [31:0] reqAddr;
    logic [63:0] e;
    int          due;
    pend_t       p;
    imem_req_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(pend[0].addr);
      rspLive        = pend[0].live;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      rspLive        = 1'b0;
    end
    #1;
    stale = 0;
    foreach (pend[i]) if (!pend[i].live) stale++;
    expReqValid = !redirect_valid && (stale == 0) && (pend.size() + bufCount < DEPTH);
    check("req_valid", 64'(imem_req_valid), 64'(expReqValid));
    check("instr_valid", 64'(instr_valid), 64'(bufCount != 0 && !redirect_valid));
    check("fq_count", 64'(fq_count), 64'(bufCount));
    check("credit", 64'(pend.size() + int'(fq_count) <= DEPTH), 64'(1));
    if (imem_req_valid) check("imem_addr", 64'(imem_addr), 64'(expAddr));
    reqFire = imem_req_valid && imem_req_ready;
    reqAddr = imem_addr;
    rspFire = imem_rsp_valid;
    popFire = instr_valid && instr_ready;
    if (popFire) begin
      if (firstPopCyc < 0) begin
        firstPopCyc = cyc;
        firstPopPc  = instr_pc;
      end
      if (waitFirst) begin
        firstPcAfter = instr_pc;
        waitFirst    = 0;
      end
      if (exp_q.size() == 0) begin
        check("pop_when_empty", 64'(popFire), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", 64'(instr_pc), 64'(e[63:32]));
        check("instr_data", 64'(instr_data), 64'(e[31:0]));
      end
    end
    @(posedge clk);
    if (rspFire) void'(pend.pop_front());
    if (redirect_valid) begin
      foreach (pend[i]) pend[i].live = 1'b0;
      exp_q.delete();
      bufCount  = 0;
      expAddr   = {redirect_pc[31:2], 2'b00};
      waitFirst = 1;
    end else begin
      if (rspFire && rspLive) bufCount++;
      if (popFire) bufCount--;
    end
    if (reqFire) begin
      due = cyc + (randLat ? int'($urandom_range(1, 5)) : lat);
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      p.addr  = reqAddr;
      p.due   = due;
      p.live  = !redirect_valid;
      pend.push_back(p);
      if (!redirect_valid) begin
        exp_q.push_back({reqAddr, memWord(reqAddr)});
        expAddr = expAddr + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;

    // L=1, decode always ready: first instruction at cycle 2, then 1/cycle
    lat = 1;
    repeat (12) step();
    check("first_pop_cycle", 64'(firstPopCyc), 64'(2));
    check("first_pop_pc", 64'(firstPopPc), 64'(RESET_PC));

    // decode stalled: buffer fills and issue stops, then drains in order
    instr_ready = 1'b0;
    repeat (10) step();
    check("full_count", 64'(fq_count), 64'(DEPTH));
    check("full_req_valid", 64'(imem_req_valid), 64'(0));
    instr_ready = 1'b1;
    repeat (10) step();

    // L=3 with 3 in flight, redirect to a misaligned target
    lat = 3;
    for (int i = 0; i < 20 && pend.size() != 3; i++) step();
    check("setup_three_in_flight", 64'(pend.size()), 64'(3));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    repeat (14) step();
    check("redirect_first_pc", 64'(firstPcAfter), 64'(32'h8000_0100));

    // redirect coinciding with an arriving response and a pop
    lat = 2;
    for (int i = 0; i < 30 && !(bufCount > 0 && pend.size() > 0 && pend[0].due <= cyc); i++) step();
    check("setup_rsp_pop", 64'(bufCount > 0 && pend.size() > 0 && pend[0].due <= cyc), 64'(1));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0043;
    step();
    redirect_valid = 1'b0;
    check("flush_count", 64'(fq_count), 64'(0));
    check("flush_instr_valid", 64'(instr_valid), 64'(0));
    repeat (12) step();

    // random ready, latency 1..5, occasional (sometimes back-to-back) redirects
    randReady = 1;
    randLat   = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000 + 32'($urandom_range(0, 1023));
      end else begin
        redirect_valid = 1'b0;
      end
      instr_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    redirect_valid = 1'b0;
    randReady      = 0;
    randLat        = 0;
    instr_ready    = 1'b1;
    repeat (12) step();

    // reset with 2 in flight and 2 buffered
    redirect_valid = 1'b1;
    redirect_pc    = RESET_PC + 32'h200;
    step();
    redirect_valid = 1'b0;
    lat            = 2;
    instr_ready    = 1'b0;
    for (int i = 0; i < 30 && !(pend.size() == 2 && bufCount == 2); i++) step();
    check("setup_2_2", 64'(pend.size() == 2 && bufCount == 2), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    checkResetOutputs("async_reset");
    pend.delete();
    exp_q.delete();
    bufCount  = 0;
    expAddr   = RESET_PC;
    lastDue   = -1;
    waitFirst = 0;
    @(negedge clk);
    reset       = 1'b0;
    cyc         = 0;
    lat         = 1;
    instr_ready = 1'b1;
    check("post_reset_addr", 64'(imem_addr), 64'(RESET_PC));
    repeat (10) step();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
